// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Control stage in front of alu_unit. Takes one decoded instruction at a
//   time, fetches the memory operand (with an optional indirect-address read),
//   drives alu_code and the AC/DR/E strobes, and walks register-reference
//   microops one per cycle, highest bit first.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | ready for an instruction; decode happens on accept
//   IND   | indirect-address read outstanding (mem_rd_ind high)
//   RD    | operand read outstanding; dr_ld follows mem_rd_ack
//   EXEC  | one cycle: alu_code for AND/ADD/LDA/INP with ac_ld
//   REG   | serve highest pending microop bit, one per cycle
//   DONE  | done pulse (with illegal if flagged), back to IDLE
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   instr_valid/instr_ready       instruction handshake, ir_outdata[15:0]
//   mem_rd_req/mem_rd_ind/ack     memory read handshake
//   dr_ld                         DR load (RD state and ack, combinational)
//   alu_code[3:0], ac_ld          ALU operation and AC load
//   ac_clr, e_clr, ac_inr         CLA / CLE / INC strobes
//   done, illegal                 completion pulse, not-handled flag

module alu_op_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] ir_outdata,
    output logic        mem_rd_req,
    output logic        mem_rd_ind,
    input  logic        mem_rd_ack,
    output logic        dr_ld,
    output logic [3:0]  alu_code,
    output logic        ac_ld,
    output logic        ac_clr,
    output logic        e_clr,
    output logic        ac_inr,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        IND  = 3'd1,
        RD   = 3'd2,
        EXEC = 3'd3,
        REG  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t      state;
    logic [2:0]  op_q;
    logic [6:0]  pending;      // [6]=CLA(b11) ... [0]=INC(b5)
    logic        illegal_q;
    logic [6:0]  srv;          // one-hot: microop served this cycle
    logic [6:0]  pending_nxt;

    // skip/halt bits are handled elsewhere
    logic unused_ir;
    assign unused_ir = ^ir_outdata[4:0];

    always_comb begin
        srv = 7'b0000000;
        casez (pending)
            7'b1??????: srv = 7'b1000000;
            7'b01?????: srv = 7'b0100000;
            7'b001????: srv = 7'b0010000;
            7'b0001???: srv = 7'b0001000;
            7'b00001??: srv = 7'b0000100;
            7'b000001?: srv = 7'b0000010;
            7'b0000001: srv = 7'b0000001;
            default:    srv = 7'b0000000;
        endcase
        pending_nxt = pending & ~srv;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= 3'b000;
            pending   <= 7'b0000000;
            illegal_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (instr_valid) begin
                        op_q      <= ir_outdata[14:12];
                        illegal_q <= 1'b0;
                        if (ir_outdata[14:12] < 3'd3) begin
                            state <= ir_outdata[15] ? IND : RD;
                        end else if (ir_outdata[15:12] == 4'b0111) begin
                            pending <= ir_outdata[11:5];
                            // no microop bits set: nothing to walk
                            state   <= (|ir_outdata[11:5]) ? REG : DONE;
                        end else if (ir_outdata[15:12] == 4'b1111 && ir_outdata[11]) begin
                            state <= EXEC;
                        end else begin
                            illegal_q <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                IND: if (mem_rd_ack) state <= RD;
                RD:  if (mem_rd_ack) state <= EXEC;
                EXEC: state <= DONE;
                REG: begin
                    pending <= pending_nxt;
                    if (pending_nxt == 7'b0000000) state <= DONE;
                end
                DONE: begin
                    illegal_q <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only (dr_ld adds the ack); reset
    // forces them all low so it overrides every input in its own cycle.
    always_comb begin
        instr_ready = 1'b0;
        mem_rd_req  = 1'b0;
        mem_rd_ind  = 1'b0;
        dr_ld       = 1'b0;
        alu_code    = 4'b0000;
        ac_ld       = 1'b0;
        ac_clr      = 1'b0;
        e_clr       = 1'b0;
        ac_inr      = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: instr_ready = 1'b1;
                IND: begin
                    mem_rd_req = 1'b1;
                    mem_rd_ind = 1'b1;
                end
                RD: begin
                    mem_rd_req = 1'b1;
                    dr_ld      = mem_rd_ack;
                end
                EXEC: begin
                    ac_ld = 1'b1;
                    case (op_q)
                        3'b000:  alu_code = 4'b0001;
                        3'b001:  alu_code = 4'b0010;
                        3'b010:  alu_code = 4'b0011;
                        default: alu_code = 4'b1101;   // INP
                    endcase
                end
                REG: begin
                    unique case (1'b1)
                        srv[6]: ac_clr = 1'b1;
                        srv[5]: e_clr  = 1'b1;
                        srv[4]: begin alu_code = 4'b1001; ac_ld = 1'b1; end
                        srv[3]: alu_code = 4'b1010;   // CME only touches E
                        srv[2]: begin alu_code = 4'b1011; ac_ld = 1'b1; end
                        srv[1]: begin alu_code = 4'b1100; ac_ld = 1'b1; end
                        srv[0]: ac_inr = 1'b1;
                        default: ;
                    endcase
                end
                DONE: begin
                    done    = 1'b1;
                    illegal = illegal_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer. Each cycle drives inputs just after
// the rising edge and compares the full output vector at the falling edge
// against hand-computed values.
//   vector bits: {instr_ready, mem_rd_req, mem_rd_ind, dr_ld, alu_code[3:0],
//                 ac_ld, ac_clr, e_clr, ac_inr, done, illegal}

module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] ir_outdata;
    logic        mem_rd_req;
    logic        mem_rd_ind;
    logic        mem_rd_ack;
    logic        dr_ld;
    logic [3:0]  alu_code;
    logic        ac_ld;
    logic        ac_clr;
    logic        e_clr;
    logic        ac_inr;
    logic        done;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .ir_outdata  (ir_outdata),
        .mem_rd_req  (mem_rd_req),
        .mem_rd_ind  (mem_rd_ind),
        .mem_rd_ack  (mem_rd_ack),
        .dr_ld       (dr_ld),
        .alu_code    (alu_code),
        .ac_ld       (ac_ld),
        .ac_clr      (ac_clr),
        .e_clr       (e_clr),
        .ac_inr      (ac_inr),
        .done        (done),
        .illegal     (illegal)
    );

    logic [13:0] obs;
    assign obs = {instr_ready, mem_rd_req, mem_rd_ind, dr_ld, alu_code,
                  ac_ld, ac_clr, e_clr, ac_inr, done, illegal};

    localparam logic [13:0] O_ZERO = 14'b0;
    localparam logic [13:0] O_IDLE = 14'b1_0_0_0_0000_000000;
    localparam logic [13:0] O_REQ  = 14'b0_1_0_0_0000_000000;
    localparam logic [13:0] O_IND  = 14'b0_1_1_0_0000_000000;
    localparam logic [13:0] O_DRLD = 14'b0_1_0_1_0000_000000;
    localparam logic [13:0] O_DONE = 14'b0_0_0_0_0000_000010;
    localparam logic [13:0] O_ILL  = 14'b0_0_0_0_0000_000011;
    localparam logic [13:0] O_CLR  = 14'b0_0_0_0_0000_010000;
    localparam logic [13:0] O_ECLR = 14'b0_0_0_0_0000_001000;
    localparam logic [13:0] O_INR  = 14'b0_0_0_0_0000_000100;

    // alu_code with optional ac_ld
    function automatic logic [13:0] alu(input logic [3:0] code, input logic ld);
        return {4'b0000, code, ld, 5'b00000};
    endfunction

    task automatic cyc(input string tag, input logic v, input logic [15:0] ir,
                       input logic ack, input logic r, input logic [13:0] exp);
        rst         = r;
        instr_valid = v;
        ir_outdata  = ir;
        mem_rd_ack  = ack;
        @(negedge clk);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; ir_outdata = 16'h0000; mem_rd_ack = 1'b0;
        @(posedge clk);
        #1;

        // reset: outputs low even with inputs active
        cyc("rst0",      1, 16'h1123, 1, 1, O_ZERO);
        cyc("rst1",      0, 16'h0000, 0, 1, O_ZERO);
        cyc("idle",      0, 16'h0000, 1, 0, O_IDLE);

        // ADD direct, ack after two wait cycles; busy instr_valid ignored
        cyc("add_c0",    1, 16'h1123, 0, 0, O_IDLE);
        cyc("add_c1",    0, 16'h0000, 0, 0, O_REQ);
        cyc("add_c2",    1, 16'h3000, 0, 0, O_REQ);
        cyc("add_c3",    0, 16'h0000, 1, 0, O_DRLD);
        cyc("add_c4",    0, 16'h0000, 1, 0, alu(4'b0010, 1));
        cyc("add_c5",    0, 16'h0000, 0, 0, O_DONE);
        cyc("add_c6",    0, 16'h0000, 0, 0, O_IDLE);

        // LDA indirect; ack in IND gives no dr_ld
        cyc("lda_c0",    1, 16'hA050, 0, 0, O_IDLE);
        cyc("lda_c1",    0, 16'h0000, 0, 0, O_IND);
        cyc("lda_c2",    0, 16'h0000, 1, 0, O_IND);
        cyc("lda_c3",    0, 16'h0000, 0, 0, O_REQ);
        cyc("lda_c4",    0, 16'h0000, 1, 0, O_DRLD);
        cyc("lda_c5",    0, 16'h0000, 0, 0, alu(4'b0011, 1));
        cyc("lda_c6",    0, 16'h0000, 0, 0, O_DONE);
        cyc("lda_c7",    0, 16'h0000, 0, 0, O_IDLE);

        // AND direct, ack in first cycle (zero wait)
        cyc("and_c0",    1, 16'h0005, 0, 0, O_IDLE);
        cyc("and_c1",    0, 16'h0000, 1, 0, O_DRLD);
        cyc("and_c2",    0, 16'h0000, 0, 0, alu(4'b0001, 1));
        cyc("and_c3",    0, 16'h0000, 0, 0, O_DONE);

        // CMA + CIL
        cyc("cma_c0",    1, 16'h7240, 0, 0, O_IDLE);
        cyc("cma_c1",    0, 16'h0000, 0, 0, alu(4'b1001, 1));
        cyc("cil_c2",    0, 16'h0000, 0, 0, alu(4'b1100, 1));
        cyc("cmacil_c3", 0, 16'h0000, 0, 0, O_DONE);
        cyc("cmacil_c4", 0, 16'h0000, 0, 0, O_IDLE);

        // CME alone: alu_code without ac_ld
        cyc("cme_c0",    1, 16'h7100, 0, 0, O_IDLE);
        cyc("cme_c1",    0, 16'h0000, 0, 0, alu(4'b1010, 0));
        cyc("cme_c2",    0, 16'h0000, 0, 0, O_DONE);

        // CIR with skip/halt bits set (ignored)
        cyc("cir_c0",    1, 16'h709F, 0, 0, O_IDLE);
        cyc("cir_c1",    0, 16'h0000, 0, 0, alu(4'b1011, 1));
        cyc("cir_c2",    0, 16'h0000, 0, 0, O_DONE);

        // CLA + CLE + INC
        cyc("cci_c0",    1, 16'h7C20, 0, 0, O_IDLE);
        cyc("cla_c1",    0, 16'h0000, 0, 0, O_CLR);
        cyc("cle_c2",    0, 16'h0000, 0, 0, O_ECLR);
        cyc("inc_c3",    0, 16'h0000, 0, 0, O_INR);
        cyc("cci_c4",    0, 16'h0000, 0, 0, O_DONE);

        // empty register-ref mask
        cyc("nop_c0",    1, 16'h7000, 0, 0, O_IDLE);
        cyc("nop_c1",    0, 16'h0000, 0, 0, O_DONE);
        cyc("nop_c2",    0, 16'h0000, 0, 0, O_IDLE);

        // INP
        cyc("inp_c0",    1, 16'hF800, 0, 0, O_IDLE);
        cyc("inp_c1",    0, 16'h0000, 0, 0, alu(4'b1101, 1));
        cyc("inp_c2",    0, 16'h0000, 0, 0, O_DONE);

        // STA and I/O without bit 11: illegal
        cyc("sta_c0",    1, 16'h3000, 0, 0, O_IDLE);
        cyc("sta_c1",    0, 16'h0000, 0, 0, O_ILL);
        cyc("io_c0",     1, 16'hF400, 0, 0, O_IDLE);
        cyc("io_c1",     0, 16'h0000, 0, 0, O_ILL);
        // the illegal flag must not stick to the next instruction
        cyc("post_c0",   1, 16'h7000, 0, 0, O_IDLE);
        cyc("post_c1",   0, 16'h0000, 0, 0, O_DONE);

        // reset during RD wait; late ack ignored
        cyc("rrd_c0",    1, 16'h1123, 0, 0, O_IDLE);
        cyc("rrd_c1",    0, 16'h0000, 0, 0, O_REQ);
        cyc("rrd_c2",    0, 16'h0000, 0, 1, O_ZERO);
        cyc("rrd_c3",    0, 16'h0000, 1, 0, O_IDLE);
        cyc("rrd_c4",    0, 16'h0000, 0, 0, O_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
